// File: rtl/control_bus_rtc.sv
// control_bus_rtc: RTC register-bus sequencer, round-robin write bursts ahead of a one-deep pending read burst (CRONO_WRITE_EN enables crono writes).
// Latency: GRANT one cycle after a request is seen in IDLE, bursts of 3*CICLO_N+2 (write) / 9*CICLO_N+2 (read) cycles; requests wait, bursts never preempted.
module control_bus_rtc #(
  parameter int CICLO_N = 8
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       tick_lectura,
  input  logic       req_hora,
  input  logic       req_fecha,
  input  logic       req_crono,
  output logic [3:0] Selec_Demux_DD,
  output logic       READ,
  output logic       acceso,
  output logic       ack_hora,
  output logic       ack_fecha,
  output logic       ack_crono,
  output logic       fin_lectura,
  output logic       ocupado
);

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, FIN} state_t;

`ifdef CRONO_WRITE_EN
  localparam int NWR = 3;
`else
  localparam int NWR = 2;
`endif
  localparam logic [1:0] OWN_READ = 2'd3;
  localparam logic [3:0] CNT_LAST = 4'(CICLO_N - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic       read_q, read_d;
  logic       pend_q, pend_d;

  logic [2:0] wreq;
  logic       win_vld;
  logic [1:0] win;
  logic [1:0] cand;

`ifdef CRONO_WRITE_EN
  assign wreq = {req_crono, req_fecha, req_hora};
`else
  logic crono_unused;
  assign crono_unused = req_crono;
  assign wreq = {1'b0, req_fecha, req_hora};
`endif

  // Round-robin: search starts at ptr_q, the writer after the last one granted.
  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < NWR; k++) begin
      cand = 2'((int'(ptr_q) + k) % NWR);
      if (!win_vld && wreq[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    read_d  = read_q;
    pend_d  = pend_q | tick_lectura;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          owner_d = win;
          read_d  = 1'b0;
          idx_d   = 4'(win) * 4'd3;
          last_d  = 4'(win) * 4'd3 + 4'd2;
          ptr_d   = 2'((int'(win) + 1) % NWR);
        end else if (pend_q || tick_lectura) begin
          state_d = GRANT;
          owner_d = OWN_READ;
          read_d  = 1'b1;
          idx_d   = 4'd0;
          last_d  = 4'd8;
          pend_d  = 1'b0;
        end
      end
      GRANT: begin
        state_d = ACCESS;
        cnt_d   = 4'd0;
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 4'd0;
          if (idx_q == last_q) begin
            state_d = FIN;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      last_q  <= 4'd0;
      cnt_q   <= 4'd0;
      owner_q <= OWN_READ;
      ptr_q   <= 2'd0;
      read_q  <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      read_q  <= read_d;
      pend_q  <= pend_d;
    end
  end

  assign Selec_Demux_DD = idx_q;
  assign READ           = read_q;
  assign acceso         = (state_q == ACCESS);
  assign ocupado        = (state_q != IDLE);
  assign fin_lectura    = (state_q == FIN) && (owner_q == OWN_READ);
  assign ack_hora       = (state_q == FIN) && (owner_q == 2'd0);
  assign ack_fecha      = (state_q == FIN) && (owner_q == 2'd1);
`ifdef CRONO_WRITE_EN
  assign ack_crono      = (state_q == FIN) && (owner_q == 2'd2);
`else
  assign ack_crono      = 1'b0;
`endif

endmodule

// File: tb/tb_control_bus_rtc.sv
// Bench for control_bus_rtc: directed stimulus pushes expected bursts into a scoreboard;
// a negedge monitor tracks each burst from GRANT to its completion pulse and compares.
module tb_control_bus_rtc;
  localparam int N = 8;

  logic       reloj = 1'b0;
  logic       resetM, tick_lectura, req_hora, req_fecha, req_crono;
  logic [3:0] sel;
  logic       rd, acceso, ack_hora, ack_fecha, ack_crono, fin_lectura, ocupado;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int kind;
    int start;
    int last;
    int rd;
    int done;
  } exp_t;
  exp_t sb[$];

  control_bus_rtc #(.CICLO_N(N)) dut (
    .reloj(reloj), .resetM(resetM), .tick_lectura(tick_lectura),
    .req_hora(req_hora), .req_fecha(req_fecha), .req_crono(req_crono),
    .Selec_Demux_DD(sel), .READ(rd), .acceso(acceso),
    .ack_hora(ack_hora), .ack_fecha(ack_fecha), .ack_crono(ack_crono),
    .fin_lectura(fin_lectura), .ocupado(ocupado)
  );

  always #5 reloj = ~reloj;
  always @(posedge reloj) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int start, input int last, input int r, input int done);
    exp_t e;
    e.kind = kind; e.start = start; e.last = last; e.rd = r; e.done = done;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge reloj);
    #1;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int seen = 0;
    int i = 0;
    while (seen < n && i < budget) begin
      @(negedge reloj);
      if (ack_hora || ack_fecha || ack_crono || fin_lectura) seen++;
      i++;
    end
    if (seen < n) check(1'b0, "pulse_timeout", seen, n);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    bit done = 1'b0;
    while (!done && i < budget) begin
      @(negedge reloj);
      done = !ocupado && (sb.size() == 0);
      i++;
    end
    if (!done) check(1'b0, "idle_timeout", sb.size(), 0);
  endtask

  // Monitor state
  bit   rst_prev = 1'b0;
  bit   in_burst = 1'b0;
  int   g_cyc, g_read, g_start, last_idx, dwell, bad, npulse, kind, id_act, id_exp, len_exp;
  exp_t e;

  initial begin
    forever begin
      @(negedge reloj);
      if (rst_prev)
        check({sel, rd, acceso, ocupado, ack_hora, ack_fecha, ack_crono, fin_lectura} == 11'h040,
              "reset_outputs",
              int'({sel, rd, acceso, ocupado, ack_hora, ack_fecha, ack_crono, fin_lectura}), 'h40);
      if (resetM) begin
        in_burst = 1'b0;
      end else begin
        npulse = int'(ack_hora) + int'(ack_fecha) + int'(ack_crono) + int'(fin_lectura);
        if (ocupado && !acceso && !in_burst && npulse == 0) begin
          in_burst = 1'b1;
          g_cyc    = cyc;
          g_read   = int'(rd);
          g_start  = int'(sel);
          last_idx = int'(sel);
          dwell    = 0;
          bad      = 0;
        end else if (acceso && in_burst) begin
          if (int'(sel) == last_idx) begin
            dwell++;
          end else begin
            if (dwell != N) bad++;
            if (int'(sel) != last_idx + 1) bad++;
            last_idx = int'(sel);
            dwell    = 1;
          end
        end
        if (npulse > 0) begin
          check(npulse == 1, "single_owner_pulse", npulse, 1);
          kind = ack_hora ? 0 : ack_fecha ? 1 : ack_crono ? 2 : 3;
          if (dwell != N) bad++;
          check(sb.size() > 0, "pulse_expected", kind, -1);
          if (sb.size() > 0) begin
            e       = sb.pop_front();
            id_act  = kind * 1000 + g_start * 100 + last_idx * 10 + g_read;
            id_exp  = e.kind * 1000 + e.start * 100 + e.last * 10 + e.rd;
            len_exp = (e.rd != 0) ? 9 * N + 2 : 3 * N + 2;
            check(id_act == id_exp, "burst_owner_idx_read", id_act, id_exp);
            check(cyc == e.done, "burst_done_cycle", cyc, e.done);
            check(cyc - g_cyc + 1 == len_exp, "burst_length", cyc - g_cyc + 1, len_exp);
            check(bad == 0, "burst_index_dwell", bad, 0);
          end
          in_burst = 1'b0;
        end
      end
      rst_prev = resetM;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    resetM = 1'b1; tick_lectura = 1'b0;
    req_hora = 1'b0; req_fecha = 1'b0; req_crono = 1'b0;
    step(3);
    resetM = 1'b0;
    step(2);

    // Single read burst: indices 0..8, fin_lectura 74 cycles after the tick
    c = cyc;
    push(3, 0, 8, 1, c + 74);
    tick_lectura = 1'b1; step(1); tick_lectura = 1'b0;
    wait_idle(200);
    step(1);

    // All writers held: round-robin order from reset pointer (hora first)
    c = cyc;
`ifdef CRONO_WRITE_EN
    push(0, 0, 2, 0, c + 26); push(1, 3, 5, 0, c + 53);
    push(2, 6, 8, 0, c + 80); push(0, 0, 2, 0, c + 107);
`else
    push(0, 0, 2, 0, c + 26); push(1, 3, 5, 0, c + 53);
    push(0, 0, 2, 0, c + 80); push(1, 3, 5, 0, c + 107);
`endif
    req_hora = 1'b1; req_fecha = 1'b1; req_crono = 1'b1;
    wait_pulses(3, 200);
    @(negedge reloj);
    @(negedge reloj);
    // Dropped during GRANT of the fourth burst: that burst must still complete
    req_hora = 1'b0; req_fecha = 1'b0; req_crono = 1'b0;
    wait_idle(200);
    step(1);

    // Single hora write, dropped on its ack
    c = cyc;
    push(0, 0, 2, 0, c + 26);
    req_hora = 1'b1;
    wait_pulses(1, 100);
    req_hora = 1'b0;
    step(3);
    check(!ocupado, "idle_after_write", int'(ocupado), 0);

    // Tick with req_fecha together, two extra ticks mid-burst: fecha then one read
    c = cyc;
    push(1, 3, 5, 0, c + 26);
    push(3, 0, 8, 1, c + 101);
    tick_lectura = 1'b1; req_fecha = 1'b1; step(1); tick_lectura = 1'b0;
    step(4);
    tick_lectura = 1'b1; step(1); tick_lectura = 1'b0;
    step(4);
    tick_lectura = 1'b1; step(1); tick_lectura = 1'b0;
    wait_pulses(1, 100);
    req_fecha = 1'b0;
    wait_idle(300);
    step(1);

    // Crono writer alone
`ifdef CRONO_WRITE_EN
    c = cyc;
    push(2, 6, 8, 0, c + 26);
    req_crono = 1'b1;
    wait_pulses(1, 100);
    req_crono = 1'b0;
    step(3);
    check(!ocupado, "idle_after_crono", int'(ocupado), 0);
`else
    req_crono = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge reloj);
      check(!ocupado && !ack_crono, "crono_ignored",
            int'({ocupado, ack_crono}), 0);
    end
    req_crono = 1'b0;
`endif
    step(1);

    // Reset at index 4 of a read burst; held req_hora served afterwards
    c = cyc;
    tick_lectura = 1'b1; step(1); tick_lectura = 1'b0;
    step(9);
    req_hora = 1'b1;
    step(26);
    check(sel == 4'd4, "index_before_reset", int'(sel), 4);
    resetM = 1'b1;
    step(1);
    resetM = 1'b0;
    push(0, 0, 2, 0, c + 63);
    wait_pulses(1, 100);
    req_hora = 1'b0;
    wait_idle(100);

    step(2);
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
